memwb_skid_stage: RTL and testbench

//  Parametrised MEM/WB pipeline stage with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/memwb_skid_stage.sv | 205 ++++++++++++++++++++
 tb/tb_memwb_skid_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memwb_skid_stage.sv
// memwb_skid_stage: MEM/WB pipeline stage with a valid/ready handshake and a
// two-entry skid buffer. The head register H drives the outputs and the skid
// register S absorbs one extra entry. Because of S, in_ready can come from a
// register instead of being a combinational function of out_ready.
module memwb_skid_stage #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RD_W        = 5,
    parameter int unsigned ROB_IDX_W   = 4,
    parameter int unsigned ITYPE_W     = 3,
    parameter bit          SUPPRESS_X0 = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_alu_out,
    input  logic [DATA_W-1:0]    in_mem_out,
    input  logic [RD_W-1:0]      in_rd,
    input  logic                 in_mem_to_reg,
    input  logic                 in_write_enable,
    input  logic                 in_complete,
    input  logic [ROB_IDX_W-1:0] in_complete_idx,
    input  logic [ITYPE_W-1:0]   in_instr_type,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_alu_out,
    output logic [DATA_W-1:0]    out_mem_out,
    output logic [DATA_W-1:0]    out_wb_data,
    output logic [RD_W-1:0]      out_rd,
    output logic                 out_mem_to_reg,
    output logic                 out_write_enable,
    output logic                 out_complete,
    output logic [ROB_IDX_W-1:0] out_complete_idx,
    output logic [ITYPE_W-1:0]   out_instr_type
);

    // Payload without the two qualified flags (write_enable, complete).
    // The flags are held separately so that they can be cleared when the
    // stage empties while the payload keeps its stale value.
    localparam int unsigned PAY_W = 3 * DATA_W + RD_W + 1 + ROB_IDX_W + ITYPE_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_in_ready;
    logic               r_out_valid;

    logic [PAY_W-1:0]   r_h_pay;
    logic               r_h_we;
    logic               r_h_cmp;
    logic [PAY_W-1:0]   r_s_pay;
    logic               r_s_we;
    logic               r_s_cmp;

    logic [DATA_W-1:0]  w_in_wb_data;
    logic               w_in_we;
    logic [PAY_W-1:0]   w_in_pay;

    logic               w_accept;
    logic               w_drain;

    logic               w_h_load_in;
    logic               w_h_load_s;
    logic               w_s_load;
    logic               w_h_clr;

    // The WB data mux and the x0 suppression sit in front of the capture registers.
    assign w_in_wb_data = in_mem_to_reg ? in_mem_out : in_alu_out;
    assign w_in_we      = in_write_enable & ((!SUPPRESS_X0) | (in_rd != '0));
    assign w_in_pay     = {w_in_wb_data, in_alu_out, in_mem_out, in_rd,
                           in_mem_to_reg, in_complete_idx, in_instr_type};

    // Handshake qualifiers. Both are derived from registered outputs only.
    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = r_out_valid & out_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. Flush overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_drain) begin
                    w_state_nxt = ST_TWO;
                end else if (!w_accept && w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_drain) begin
                    w_state_nxt = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Datapath steering: select which storage register loads this cycle.
    always_comb begin
        w_h_load_in = 1'b0;
        w_h_load_s  = 1'b0;
        w_s_load    = 1'b0;
        w_h_clr     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_h_load_in = w_accept;
            end
            ST_ONE: begin
                w_h_load_in = w_accept & w_drain;
                w_s_load    = w_accept & !w_drain;
                w_h_clr     = !w_accept & w_drain;
            end
            ST_TWO: begin
                w_h_load_s  = w_drain;
            end
            default: begin
                w_h_clr     = 1'b1;
            end
        endcase
        if (flush) begin
            w_h_load_in = 1'b0;
            w_h_load_s  = 1'b0;
            w_s_load    = 1'b0;
            w_h_clr     = 1'b1;
        end
    end

    // Registered handshake outputs, computed from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Head register. Its flags drop together with out_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h_pay <= '0;
            r_h_we  <= 1'b0;
            r_h_cmp <= 1'b0;
        end else if (w_h_load_in) begin
            r_h_pay <= w_in_pay;
            r_h_we  <= w_in_we;
            r_h_cmp <= in_complete;
        end else if (w_h_load_s) begin
            r_h_pay <= r_s_pay;
            r_h_we  <= r_s_we;
            r_h_cmp <= r_s_cmp;
        end else if (w_h_clr) begin
            r_h_we  <= 1'b0;
            r_h_cmp <= 1'b0;
        end
    end

    // Skid register: catches the entry accepted while the head is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s_pay <= '0;
            r_s_we  <= 1'b0;
            r_s_cmp <= 1'b0;
        end else if (w_s_load) begin
            r_s_pay <= w_in_pay;
            r_s_we  <= w_in_we;
            r_s_cmp <= in_complete;
        end
    end

    // Outputs are direct register views.
    assign in_ready         = r_in_ready;
    assign out_valid        = r_out_valid;
    assign out_write_enable = r_h_we;
    assign out_complete     = r_h_cmp;
    assign {out_wb_data, out_alu_out, out_mem_out, out_rd,
            out_mem_to_reg, out_complete_idx, out_instr_type} = r_h_pay;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Testbench for memwb_skid_stage. The reference model is an ordered queue of
// held entries that is at most two deep.
module tb_memwb_skid_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_out;
    logic [31:0] in_mem_out;
    logic [4:0]  in_rd;
    logic        in_mem_to_reg;
    logic        in_write_enable;
    logic        in_complete;
    logic [3:0]  in_complete_idx;
    logic [2:0]  in_instr_type;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_out;
    logic [31:0] out_mem_out;
    logic [31:0] out_wb_data;
    logic [4:0]  out_rd;
    logic        out_mem_to_reg;
    logic        out_write_enable;
    logic        out_complete;
    logic [3:0]  out_complete_idx;
    logic [2:0]  out_instr_type;

    typedef struct packed {
        logic [31:0] wb;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  rd;
        logic        m2r;
        logic        we;
        logic        cmp;
        logic [3:0]  idx;
        logic [2:0]  ity;
    } ent_t;

    ent_t        m_q[$];
    logic        m_acc;
    logic [31:0] got[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    memwb_skid_stage dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_alu_out       (in_alu_out),
        .in_mem_out       (in_mem_out),
        .in_rd            (in_rd),
        .in_mem_to_reg    (in_mem_to_reg),
        .in_write_enable  (in_write_enable),
        .in_complete      (in_complete),
        .in_complete_idx  (in_complete_idx),
        .in_instr_type    (in_instr_type),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_alu_out      (out_alu_out),
        .out_mem_out      (out_mem_out),
        .out_wb_data      (out_wb_data),
        .out_rd           (out_rd),
        .out_mem_to_reg   (out_mem_to_reg),
        .out_write_enable (out_write_enable),
        .out_complete     (out_complete),
        .out_complete_idx (out_complete_idx),
        .out_instr_type   (out_instr_type)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] rd,
                          input logic m2r, input logic we, input logic cmp,
                          input logic [3:0] idx, input logic [2:0] ity);
        in_alu_out      = alu;
        in_mem_out      = mem;
        in_rd           = rd;
        in_mem_to_reg   = m2r;
        in_write_enable = we;
        in_complete     = cmp;
        in_complete_idx = idx;
        in_instr_type   = ity;
    endtask

    // Compare every output against the model; fields hidden behind out_valid=0 are not checked.
    task automatic check_state(input string tag);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_q.size() < 2));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk({tag, ".wb_data"}, 64'(out_wb_data), 64'(m_q[0].wb));
            chk({tag, ".alu"}, 64'(out_alu_out), 64'(m_q[0].alu));
            chk({tag, ".mem"}, 64'(out_mem_out), 64'(m_q[0].mem));
            chk({tag, ".rd"}, 64'(out_rd), 64'(m_q[0].rd));
            chk({tag, ".m2r"}, 64'(out_mem_to_reg), 64'(m_q[0].m2r));
            chk({tag, ".we"}, 64'(out_write_enable), 64'(m_q[0].we));
            chk({tag, ".complete"}, 64'(out_complete), 64'(m_q[0].cmp));
            chk({tag, ".idx"}, 64'(out_complete_idx), 64'(m_q[0].idx));
            chk({tag, ".itype"}, 64'(out_instr_type), 64'(m_q[0].ity));
        end else begin
            chk({tag, ".we_idle"}, 64'(out_write_enable), 64'd0);
            chk({tag, ".complete_idle"}, 64'(out_complete), 64'd0);
        end
    endtask

    // One clock: apply the FIFO rules to the model at the edge, then check the DUT.
    task automatic tick();
        logic acc;
        logic drn;
        ent_t e;
        if (out_valid && out_ready) got.push_back(out_alu_out);
        acc   = in_valid && (m_q.size() < 2) && reset;
        drn   = (m_q.size() > 0) && out_ready && reset;
        e.wb  = in_mem_to_reg ? in_mem_out : in_alu_out;
        e.alu = in_alu_out;
        e.mem = in_mem_out;
        e.rd  = in_rd;
        e.m2r = in_mem_to_reg;
        e.we  = in_write_enable && (in_rd != 5'd0);
        e.cmp = in_complete;
        e.idx = in_complete_idx;
        e.ity = in_instr_type;
        @(posedge clk);
        if (!reset || flush) begin
            m_q.delete();
        end else begin
            if (drn) void'(m_q.pop_front());
            if (acc) m_q.push_back(e);
        end
        m_acc = acc && !flush;
        #1;
        check_state("tick");
    endtask

    task automatic send(input string tag);
        int n;
        n        = 0;
        in_valid = 1'b1;
        m_acc    = 1'b0;
        while (!m_acc && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".accepted"}, 64'(m_acc), 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_in(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0);
        m_acc     = 1'b0;

        // Reset values
        #12;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.wb_data", 64'(out_wb_data), 64'd0);
        chk("rst.alu", 64'(out_alu_out), 64'd0);
        chk("rst.we", 64'(out_write_enable), 64'd0);
        chk("rst.complete", 64'(out_complete), 64'd0);
        reset = 1'b1;
        tick();

        // Streaming at one entry per cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(32'h10 + 32'(i), 32'h0, 5'd1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd1);
            tick();
            chk("stream.wb_data", 64'(out_wb_data), 64'(32'h10 + 32'(i)));
        end
        in_valid = 1'b0;
        tick();
        chk("stream.drained", 64'(out_valid), 64'd0);

        // Back-pressure: A and B fill the stage, C waits at the input
        got.delete();
        out_ready = 1'b0;
        set_in(32'hA, 32'h0, 5'd2, 1'b0, 1'b1, 1'b0, 4'd0, 3'd2);
        send("bp.A");
        set_in(32'hB, 32'h0, 5'd2, 1'b0, 1'b1, 1'b0, 4'd0, 3'd2);
        send("bp.B");
        chk("bp.full_in_ready", 64'(in_ready), 64'd0);
        set_in(32'hC, 32'h0, 5'd2, 1'b0, 1'b1, 1'b0, 4'd0, 3'd2);
        in_valid = 1'b1;
        repeat (3) tick();
        chk("bp.head_A", 64'(out_alu_out), 64'hA);
        out_ready = 1'b1;
        send("bp.C");
        repeat (3) tick();
        chk("bp.count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("bp.order0", 64'(got[0]), 64'hA);
            chk("bp.order1", 64'(got[1]), 64'hB);
            chk("bp.order2", 64'(got[2]), 64'hC);
        end

        // WB data mux and x0 write suppression
        set_in(32'h1, 32'hDEAD, 5'd0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd3);
        send("mux.x0");
        chk("mux.wb_data", 64'(out_wb_data), 64'hDEAD);
        chk("mux.we_x0", 64'(out_write_enable), 64'd0);
        set_in(32'h1, 32'hDEAD, 5'd3, 1'b0, 1'b1, 1'b0, 4'd0, 3'd3);
        send("mux.x3");
        chk("mux.wb_alu", 64'(out_wb_data), 64'h1);
        chk("mux.we_x3", 64'(out_write_enable), 64'd1);
        tick();

        // Flush while full with a valid input on the same cycle
        out_ready = 1'b0;
        set_in(32'h21, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, 4'd1, 3'd0);
        send("fl.A");
        set_in(32'h22, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, 4'd2, 3'd0);
        send("fl.B");
        set_in(32'h23, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, 4'd3, 3'd0);
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        chk("fl.out_valid", 64'(out_valid), 64'd0);
        chk("fl.in_ready", 64'(in_ready), 64'd1);
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();
        chk("fl.not_delivered", 64'(out_valid), 64'd0);

        // Completion flag held under stall, consumed once
        out_ready = 1'b0;
        set_in(32'h30, 32'h0, 5'd5, 1'b0, 1'b1, 1'b1, 4'd5, 3'd4);
        send("cmp.send");
        for (int i = 0; i < 3; i++) begin
            chk("cmp.held", 64'(out_complete), 64'd1);
            chk("cmp.idx", 64'(out_complete_idx), 64'd5);
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        tick();
        chk("cmp.consumed", 64'(out_complete), 64'd0);

        // Asynchronous reset while the stage is full
        out_ready = 1'b0;
        set_in(32'h41, 32'h55, 5'd6, 1'b1, 1'b1, 1'b1, 4'd7, 3'd5);
        send("ar.A");
        set_in(32'h42, 32'h66, 5'd6, 1'b1, 1'b1, 1'b1, 4'd8, 3'd5);
        send("ar.B");
        #2;
        reset = 1'b0;
        #1;
        m_q.delete();
        chk("ar.out_valid", 64'(out_valid), 64'd0);
        chk("ar.in_ready", 64'(in_ready), 64'd1);
        chk("ar.wb_data", 64'(out_wb_data), 64'd0);
        chk("ar.complete", 64'(out_complete), 64'd0);
        chk("ar.we", 64'(out_write_enable), 64'd0);
        set_in(32'h43, 32'h0, 5'd7, 1'b0, 1'b1, 1'b0, 4'd0, 3'd6);
        in_valid = 1'b1;
        tick();
        chk("ar.idle_in_reset", 64'(out_valid), 64'd0);
        reset = 1'b1;
        send("ar.first");
        chk("ar.first_valid", 64'(out_valid), 64'd1);
        chk("ar.first_alu", 64'(out_alu_out), 64'h43);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            set_in($urandom, $urandom,
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom),
                   4'($urandom), 3'($urandom));
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("rand.empty", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
